multi_timer: RTL and testbench
==============================

# multi_timer

Multi-channel, parametrised down-counting timer block for the UART/APB peripheral. It supersedes the single-channel reload timer. It adds:
- N independent channels sharing one programmable prescaler.
- Per-channel one-shot or auto-reload mode.
- Explicit start/stop control.
- Sticky interrupt flags with clear.

It sits behind the APB register file, which drives its controls and reads back counts and flags.

## Interface
- CHANNELS, 4, number of independent timer channels (1..16)
- TIMER_BITS, 16, width of each channel counter and load value
- PRESCALE_BITS, 8, width of the shared prescaler
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- prescale  in  PRESCALE_BITS  tick period minus one; 0 = tick every clk
- start  in  CHANNELS  per-channel start/restart strobe, sampled each clk
- stop  in  CHANNELS  per-channel stop strobe
- auto_reload  in  CHANNELS  1 = periodic, 0 = one-shot
- load_value  in  CHANNELS*TIMER_BITS  channel i at bits [i*TIMER_BITS +: TIMER_BITS]
- irq_clear  in  CHANNELS  per-channel sticky-flag clear strobe
- count  out  CHANNELS*TIMER_BITS  current counter per channel, same packing
- running  out  CHANNELS  channel in RUN state
- expired  out  CHANNELS  one-clk registered pulse per expiry event
- irq_flag  out  CHANNELS  sticky expiry flags
- irq  out  1  OR of irq_flag

## Operation
- **Reset values (all outputs):** count = 0, running = 0, expired = 0, irq_flag = 0, irq = 0. Internal pre_cnt = 0.
- **Prescaler:**
  - Free-running pre_cnt.
  - Combinational tick = (pre_cnt >= prescale).
  - On tick, pre_cnt <= 0; otherwise pre_cnt <= pre_cnt + 1.
  - The >= compare means that lowering prescale mid-count never causes wrap-around.
  - The prescaler runs regardless of channel state.
- **Channel FSM:** two states, IDLE (running = 0) and RUN (running = 1).
- **Per-channel priority each clk:** stop > start > tick.
  - stop: go to IDLE. count holds its value. No expiry.
  - start (from IDLE or RUN): count <= load_value, go to RUN. Any tick in the same clk is ignored.
  - tick in RUN with count != 0: count <= count - 1.
  - tick in RUN with count == 0: expiry event.
    - If auto_reload = 1: count <= load_value as presented in that clk, stay in RUN.
    - Otherwise: go to IDLE, count stays 0.
  - IDLE ignores ticks.
- **Expiry period:** load_value + 1 ticks. load_value = 0 therefore expires on every tick.
- **expired[i]:** registered; high for exactly the clk following the edge that performed the expiry.
- **irq_flag[i]:**
  - Set on expiry; cleared by irq_clear[i].
  - Simultaneous set and clear: set wins.
- **irq:** combinational OR of the registered flags.
- **Channel independence:** channels never interact except through the shared tick.
- **Arithmetic:** unsigned, TIMER_BITS wide. Decrement never underflows because count == 0 is the expiry case.
- **Async reset mid-operation:** returns everything to the reset values immediately. Pending pulses are lost.

## Timing
- **Start latency:** start sampled at edge T gives count = load_value and running = 1 after T.
- **prescale = 0, start at edge T with load L:**
  - count reaches 0 after edge T+L.
  - Expiry at edge T+L+1.
  - expired is high during cycle T+L+1 → T+L+2.
  - In auto-reload mode, subsequent expiries every L+1 clks.
- **prescale = P:** decrements occur every P+1 clks. First-tick phase depends on the free-running pre_cnt.
- **stop:** takes effect at the sampling edge. No expiry can occur at that edge.
- **Flag/irq timing:** irq_flag and irq rise in the same cycle as expired.

## Test plan
- Reset, prescale = 0, ch0 one-shot, L = 5, start at edge T → count 5,4,3,2,1,0. expired[0] pulses once after edge T+6. running[0] falls at T+6. irq_flag[0] = 1 and irq = 1 until irq_clear[0].
- ch1 auto-reload, L = 3, prescale = 0 → expired[1] every 4 clks for at least 5 periods. Change load_value to 1 mid-run → the next reload uses 1, giving a 2-clk period thereafter.
- prescale = 4, ch2 auto-reload, L = 0 → expired[2] exactly every 5 clks. Drop prescale to 1 while pre_cnt = 3 → the next tick occurs on the following clk with no wrap stall, then every 2 clks.
- Simultaneous events on ch3:
  - stop+start in the same clk → stays IDLE, count held.
  - irq_clear in the same clk as expiry → irq_flag[3] remains 1.
  - start in the same clk as expiry tick → reload to load_value, no expired pulse.
- All channels running with distinct L, then rst_n asserted mid-count → all outputs 0 asynchronously. After release, no channel runs until started.
- load_value = 2^TIMER_BITS-1, prescale = 0, one-shot → expiry after exactly 2^TIMER_BITS clks with no underflow or wrap.

Source files
------------

// File: rtl/multi_timer_if.sv
// Control/status bundle between the APB register file and the multi-channel timer.
// Channel i occupies bits [i*TIMER_BITS +: TIMER_BITS] of load_value and count.
interface multi_timer_if #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned TIMER_BITS    = 16,
  parameter int unsigned PRESCALE_BITS = 8
);
  logic [PRESCALE_BITS-1:0]       prescale;
  logic [CHANNELS-1:0]            start;
  logic [CHANNELS-1:0]            stop;
  logic [CHANNELS-1:0]            auto_reload;
  logic [CHANNELS*TIMER_BITS-1:0] load_value;
  logic [CHANNELS-1:0]            irq_clear;
  logic [CHANNELS*TIMER_BITS-1:0] count;
  logic [CHANNELS-1:0]            running;
  logic [CHANNELS-1:0]            expired;
  logic [CHANNELS-1:0]            irq_flag;
  logic                           irq;

  modport master (
    output prescale, start, stop, auto_reload, load_value, irq_clear,
    input  count, running, expired, irq_flag, irq
  );

  modport slave (
    input  prescale, start, stop, auto_reload, load_value, irq_clear,
    output count, running, expired, irq_flag, irq
  );
endinterface

// File: rtl/multi_timer.sv
// N-channel down-counting timer with a shared free-running prescaler,
// per-channel one-shot/auto-reload, start/stop control and sticky IRQ flags.
module multi_timer #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned TIMER_BITS    = 16,
  parameter int unsigned PRESCALE_BITS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  multi_timer_if.slave tmr
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e                   r_state   [CHANNELS];
  logic [TIMER_BITS-1:0]    r_count   [CHANNELS];
  logic [CHANNELS-1:0]      r_running;
  logic [CHANNELS-1:0]      r_expired;
  logic [CHANNELS-1:0]      r_irq_flag;
  logic [PRESCALE_BITS-1:0] r_pre_cnt;

  logic                     w_tick;
  logic [TIMER_BITS-1:0]    w_load    [CHANNELS];
  logic [CHANNELS-1:0]      w_expire;

  // >= rather than == so that lowering prescale mid-count never forces a wrap
  always_comb begin
    w_tick = (r_pre_cnt >= tmr.prescale);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre_cnt <= '0;
    end else if (w_tick) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= r_pre_cnt + PRESCALE_BITS'(1);
    end
  end

  // Expiry only when neither stop nor start claims the cycle
  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      w_load[i]   = tmr.load_value[i*TIMER_BITS +: TIMER_BITS];
      w_expire[i] = !tmr.stop[i] && !tmr.start[i] && w_tick &&
                    (r_state[i] == S_RUN) && (r_count[i] == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_state[i] <= S_IDLE;
        r_count[i] <= '0;
      end
      r_running  <= '0;
      r_expired  <= '0;
      r_irq_flag <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_expired[i]  <= w_expire[i];
        r_irq_flag[i] <= w_expire[i] | (r_irq_flag[i] & ~tmr.irq_clear[i]);
        if (tmr.stop[i]) begin
          r_state[i]   <= S_IDLE;
          r_running[i] <= 1'b0;
        end else if (tmr.start[i]) begin
          r_count[i]   <= w_load[i];
          r_state[i]   <= S_RUN;
          r_running[i] <= 1'b1;
        end else if (w_tick && (r_state[i] == S_RUN)) begin
          if (r_count[i] != '0) begin
            r_count[i] <= r_count[i] - TIMER_BITS'(1);
          end else if (tmr.auto_reload[i]) begin
            r_count[i] <= w_load[i];
          end else begin
            r_state[i]   <= S_IDLE;
            r_running[i] <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    tmr.count = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      tmr.count[i*TIMER_BITS +: TIMER_BITS] = r_count[i];
    end
  end

  assign tmr.running  = r_running;
  assign tmr.expired  = r_expired;
  assign tmr.irq_flag = r_irq_flag;
  assign tmr.irq      = |r_irq_flag;

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: one-shot, auto-reload, prescaler retiming,
// same-cycle priority cases, async reset and full-range count.
module tb_multi_timer;

  localparam int unsigned CH = 4;
  localparam int unsigned TB = 16;
  localparam int unsigned PB = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic found;

  multi_timer_if #(.CHANNELS(CH), .TIMER_BITS(TB), .PRESCALE_BITS(PB)) bus ();

  multi_timer #(.CHANNELS(CH), .TIMER_BITS(TB), .PRESCALE_BITS(PB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tmr   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [TB-1:0] cnt(input int unsigned i);
    return bus.count[i*TB +: TB];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.prescale    = '0;
    bus.start       = '0;
    bus.stop        = '0;
    bus.auto_reload = '0;
    bus.load_value  = '0;
    bus.irq_clear   = '0;
    found           = 1'b0;

    #12;
    check("rst_count",   bus.count,    64'd0);
    check("rst_running", bus.running,  64'd0);
    check("rst_expired", bus.expired,  64'd0);
    check("rst_flag",    bus.irq_flag, 64'd0);
    check("rst_irq",     bus.irq,      64'd0);
    rst_n = 1'b1;

    // ch0 one-shot, L=5, prescale=0
    bus.load_value[15:0] = 16'd5;
    bus.start = 4'b0001;
    tick();
    bus.start = '0;
    check("c0_start_cnt", cnt(0), 64'd5);
    check("c0_start_run", bus.running[0], 64'd1);
    for (int k = 4; k >= 0; k--) begin
      tick();
      check("c0_dec_cnt", cnt(0), 64'(k));
      check("c0_dec_exp", bus.expired[0], 64'd0);
    end
    tick();
    check("c0_exp_pulse", bus.expired[0], 64'd1);
    check("c0_exp_run",   bus.running[0], 64'd0);
    check("c0_exp_flag",  bus.irq_flag[0], 64'd1);
    check("c0_exp_irq",   bus.irq, 64'd1);
    check("c0_exp_cnt",   cnt(0), 64'd0);
    tick();
    check("c0_pulse_end", bus.expired[0], 64'd0);
    check("c0_flag_hold", bus.irq_flag[0], 64'd1);
    bus.irq_clear = 4'b0001;
    tick();
    bus.irq_clear = '0;
    check("c0_flag_clr", bus.irq_flag[0], 64'd0);
    check("c0_irq_clr",  bus.irq, 64'd0);

    // ch1 auto-reload L=3, then L=1 mid-run
    bus.auto_reload[1] = 1'b1;
    bus.load_value[31:16] = 16'd3;
    bus.start = 4'b0010;
    tick();
    bus.start = '0;
    check("c1_start_cnt", cnt(1), 64'd3);
    for (int p = 0; p < 5; p++) begin
      for (int j = 0; j < 3; j++) begin
        tick();
        check("c1_p4_quiet", bus.expired[1], 64'd0);
      end
      tick();
      check("c1_p4_exp", bus.expired[1], 64'd1);
      check("c1_p4_reload", cnt(1), 64'd3);
    end
    bus.load_value[31:16] = 16'd1;
    for (int j = 0; j < 3; j++) begin
      tick();
      check("c1_chg_quiet", bus.expired[1], 64'd0);
    end
    tick();
    check("c1_chg_exp", bus.expired[1], 64'd1);
    check("c1_chg_reload", cnt(1), 64'd1);
    for (int p = 0; p < 3; p++) begin
      tick();
      check("c1_p2_quiet", bus.expired[1], 64'd0);
      tick();
      check("c1_p2_exp", bus.expired[1], 64'd1);
    end
    bus.stop = 4'b0010;
    tick();
    bus.stop = '0;
    check("c1_stop_run", bus.running[1], 64'd0);
    bus.irq_clear = 4'b0010;
    tick();
    bus.irq_clear = '0;

    // ch2 auto-reload L=0, prescale 4 then 1
    bus.prescale = 8'd4;
    bus.auto_reload[2] = 1'b1;
    bus.load_value[47:32] = 16'd0;
    bus.start = 4'b0100;
    tick();
    bus.start = '0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (bus.expired[2]) begin
        found = 1'b1;
        break;
      end
    end
    check("c2_first_exp", found, 64'd1);
    for (int p = 0; p < 2; p++) begin
      for (int j = 0; j < 4; j++) begin
        tick();
        check("c2_p5_quiet", bus.expired[2], 64'd0);
      end
      tick();
      check("c2_p5_exp", bus.expired[2], 64'd1);
    end
    for (int j = 0; j < 3; j++) begin
      tick();
      check("c2_pre_quiet", bus.expired[2], 64'd0);
    end
    // pre_cnt is 3 here; lowering to 1 must tick on the very next edge
    bus.prescale = 8'd1;
    tick();
    check("c2_drop_exp", bus.expired[2], 64'd1);
    for (int p = 0; p < 3; p++) begin
      tick();
      check("c2_p2_quiet", bus.expired[2], 64'd0);
      tick();
      check("c2_p2_exp", bus.expired[2], 64'd1);
    end
    bus.stop = 4'b0100;
    bus.prescale = 8'd0;
    bus.irq_clear = 4'b0100;
    tick();
    bus.stop = '0;
    bus.irq_clear = '0;
    check("c2_stop_run", bus.running[2], 64'd0);
    check("c2_irq_clr", bus.irq, 64'd0);

    // ch3 simultaneous events
    bus.load_value[63:48] = 16'd7;
    bus.start = 4'b1000;
    tick();
    bus.start = '0;
    tick();
    tick();
    check("c3_pre_stop_cnt", cnt(3), 64'd5);
    bus.stop = 4'b1000;
    tick();
    bus.stop = '0;
    check("c3_stop_run", bus.running[3], 64'd0);
    check("c3_stop_cnt", cnt(3), 64'd5);
    bus.load_value[63:48] = 16'd9;
    bus.stop = 4'b1000;
    bus.start = 4'b1000;
    tick();
    bus.stop = '0;
    bus.start = '0;
    check("c3_ss_run", bus.running[3], 64'd0);
    check("c3_ss_cnt", cnt(3), 64'd5);
    tick();
    check("c3_idle_cnt", cnt(3), 64'd5);

    bus.load_value[63:48] = 16'd1;
    bus.start = 4'b1000;
    tick();
    bus.start = '0;
    tick();
    check("c3_os_cnt0", cnt(3), 64'd0);
    bus.irq_clear = 4'b1000;
    tick();
    bus.irq_clear = '0;
    check("c3_clr_exp", bus.expired[3], 64'd1);
    check("c3_set_wins", bus.irq_flag[3], 64'd1);
    check("c3_os_run", bus.running[3], 64'd0);
    tick();
    check("c3_flag_hold", bus.irq_flag[3], 64'd1);
    bus.irq_clear = 4'b1000;
    tick();
    bus.irq_clear = '0;
    check("c3_flag_clr", bus.irq_flag[3], 64'd0);

    bus.auto_reload[3] = 1'b1;
    bus.load_value[63:48] = 16'd2;
    bus.start = 4'b1000;
    tick();
    bus.start = '0;
    tick();
    tick();
    check("c3_ar_cnt0", cnt(3), 64'd0);
    bus.start = 4'b1000;
    tick();
    bus.start = '0;
    check("c3_se_cnt", cnt(3), 64'd2);
    check("c3_se_exp", bus.expired[3], 64'd0);
    check("c3_se_flag", bus.irq_flag[3], 64'd0);
    check("c3_se_run", bus.running[3], 64'd1);
    tick();
    check("c3_se_next", cnt(3), 64'd1);
    bus.stop = 4'b1000;
    tick();
    bus.stop = '0;

    // all channels, then async reset mid-count
    bus.auto_reload = 4'b1111;
    bus.load_value = {16'd40, 16'd30, 16'd20, 16'd10};
    bus.start = 4'b1111;
    tick();
    bus.start = '0;
    tick();
    tick();
    tick();
    check("all_cnt", bus.count, {16'd37, 16'd27, 16'd17, 16'd7});
    check("all_run", bus.running, 64'hF);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_count",   bus.count,    64'd0);
    check("ar_running", bus.running,  64'd0);
    check("ar_expired", bus.expired,  64'd0);
    check("ar_flag",    bus.irq_flag, 64'd0);
    check("ar_irq",     bus.irq,      64'd0);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("post_rst_run", bus.running, 64'd0);
    check("post_rst_cnt", bus.count,   64'd0);

    // full-range one-shot on ch0
    bus.auto_reload = '0;
    bus.load_value[15:0] = 16'hFFFF;
    bus.start = 4'b0001;
    tick();
    bus.start = '0;
    check("max_start", cnt(0), 64'hFFFF);
    tick();
    check("max_dec", cnt(0), 64'hFFFE);
    repeat (65534) tick();
    check("max_zero_cnt", cnt(0), 64'd0);
    check("max_zero_run", bus.running[0], 64'd1);
    check("max_zero_exp", bus.expired[0], 64'd0);
    tick();
    check("max_exp",     bus.expired[0], 64'd1);
    check("max_exp_run", bus.running[0], 64'd0);
    check("max_exp_cnt", cnt(0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
